// File: rtl/store_unit_pkg.sv
// Shared definitions for the store unit: opcode values, instruction field
// positions, the decoded-instruction record and the FSM state encoding.
package store_unit_pkg;

  // Instruction opcodes (bits [2:0])
  localparam logic [2:0] OPCODE_LOAD   = 3'b000;
  localparam logic [2:0] OPCODE_STORE  = 3'b001;
  localparam logic [2:0] OPCODE_GEMM   = 3'b010;
  localparam logic [2:0] OPCODE_FINISH = 3'b011;
  localparam logic [2:0] OPCODE_ALU    = 3'b100;

  // Instruction field bit positions
  localparam int OPCODE_LSB    = 0;
  localparam int OPCODE_MSB    = 2;
  localparam int SRAM_BASE_LSB = 9;
  localparam int SRAM_BASE_MSB = 24;
  localparam int DRAM_BASE_LSB = 25;
  localparam int DRAM_BASE_MSB = 56;
  localparam int Y_SIZE_LSB    = 57;
  localparam int Y_SIZE_MSB    = 72;
  localparam int X_SIZE_LSB    = 73;
  localparam int X_SIZE_MSB    = 88;
  localparam int X_STRIDE_LSB  = 89;
  localparam int X_STRIDE_MSB  = 104;

  // Decoded STORE instruction
  typedef struct packed {
    logic [2:0]  opcode;
    logic [15:0] sram_base;
    logic [31:0] dram_base;
    logic [15:0] y_size;
    logic [15:0] x_size;
    logic [15:0] x_stride;
  } store_insn_t;

  // Tile-walk FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

endpackage

// File: rtl/store_skid_buf.sv
// Two-entry fall-through FIFO between the output-buffer read-return path and
// the outgoing beat stream. When empty, an arriving entry is presented the same
// cycle; if the consumer does not take it, it is captured so the payload stays
// stable. The occupancy output feeds the read-credit logic in the parent.
module store_skid_buf #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_last,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  input  logic              out_ready,
  output logic [1:0]        occupancy
);

  localparam int ENTRY_W = DATA_W + ADDR_W + 1;

  logic               rd_ptr_q, rd_ptr_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic [1:0]         count_q, count_d;
  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] head;
  logic               empty;
  logic               pop;
  logic               push;
  logic               pop_stored;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [ENTRY_W-1:0] entry_q, entry_d;

      // Capture the incoming entry into this slot when the write pointer selects it
      always_comb begin
        entry_d = entry_q;
        if (push && (wr_ptr_q == 1'(gi))) begin
          entry_d = in_entry;
        end
      end

      // Storage slot register
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          entry_q <= '0;
        end else begin
          entry_q <= entry_d;
        end
      end
    end
  endgenerate

  // Head selection, handshake and pointer/count bookkeeping
  always_comb begin
    in_entry   = {in_data, in_addr, in_last};
    empty      = (count_q == 2'd0);
    head       = empty ? in_entry
               : (rd_ptr_q ? g_entry[1].entry_q : g_entry[0].entry_q);
    out_valid  = in_valid || !empty;
    pop        = out_valid && out_ready;
    // An arrival that finds the FIFO empty and the consumer ready passes straight through.
    push       = in_valid && !(empty && out_ready);
    pop_stored = pop && !empty;
    rd_ptr_d   = rd_ptr_q ^ pop_stored;
    wr_ptr_d   = wr_ptr_q ^ push;
    count_d    = count_q + {1'b0, push} - {1'b0, pop_stored};
    // Payload is forced to zero whenever nothing is offered.
    out_data   = out_valid ? head[ENTRY_W-1 -: DATA_W] : '0;
    out_addr   = out_valid ? head[ADDR_W:1] : '0;
    out_last   = out_valid ? head[0] : 1'b0;
    occupancy  = count_q;
  end

  // Pointer and count registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/store_unit.sv
// store_unit: accepts one STORE instruction, walks a y_size x x_size tile of the
// output buffer one row per cycle, and streams each row with its DRAM byte
// address on a valid/ready interface. done pulses once the tile is handed off.
// Optional build macro STORE_STALL_CNT_EN adds a saturating stall_cnt output
// counting cycles with st_valid && !st_ready since the last accepted instruction.
module store_unit
  import store_unit_pkg::*;
#(
  parameter int INS_WIDTH       = 128,
  parameter int INP_MEM_WIDTH   = 128,
  parameter int ACC_IDX_WIDTH   = 12,
  parameter int DRAM_ADDR_WIDTH = 32,
  parameter int BEAT_BYTES_LOG2 = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [INS_WIDTH-1:0]       insn,
  input  logic                       insn_valid,
  output logic                       insn_ready,
  output logic [ACC_IDX_WIDTH-1:0]   out_mem_rd_addr,
  output logic                       out_mem_rd_en,
  input  logic [INP_MEM_WIDTH-1:0]   out_mem_rd_data,
  output logic                       st_valid,
  input  logic                       st_ready,
  output logic [INP_MEM_WIDTH-1:0]   st_data,
  output logic [DRAM_ADDR_WIDTH-1:0] st_addr,
  output logic                       st_last,
  output logic                       done
`ifdef STORE_STALL_CNT_EN
  ,
  output logic [31:0]                stall_cnt
`endif
);

  state_e      state_q, state_d;
  store_insn_t dec;

  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [15:0] x_size_q, x_size_d;
  logic [15:0] y_size_q, y_size_d;
  logic [15:0] x_stride_q, x_stride_d;
  logic [31:0] row_sram_q, row_sram_d;   // sram_base + y*x_size, kept incrementally
  logic [31:0] row_dram_q, row_dram_d;   // dram_base + y*x_stride, kept incrementally

  logic                       infl_q, infl_d;            // read issued last cycle
  logic [DRAM_ADDR_WIDTH-1:0] infl_addr_q, infl_addr_d;  // beat address riding with that read
  logic                       infl_last_q, infl_last_d;
  logic                       done_q, done_d;

  logic [1:0]  occupancy;
  logic [2:0]  pending;
  logic [31:0] rd_sum;
  logic [31:0] beat_word;
  logic [31:0] beat_addr_full;
  logic        row_end;
  logic        last_rd;
  logic        credit_ok;
  logic        beat_fire;
  logic        drain_clear;
  logic        accept;
  logic        unused_insn_bits;
  logic        unused_rd_sum;

  // Field extraction from the raw instruction
  always_comb begin
    dec           = '0;
    dec.opcode    = insn[OPCODE_MSB:OPCODE_LSB];
    dec.sram_base = insn[SRAM_BASE_MSB:SRAM_BASE_LSB];
    dec.dram_base = insn[DRAM_BASE_MSB:DRAM_BASE_LSB];
    dec.y_size    = insn[Y_SIZE_MSB:Y_SIZE_LSB];
    dec.x_size    = insn[X_SIZE_MSB:X_SIZE_LSB];
    dec.x_stride  = insn[X_STRIDE_MSB:X_STRIDE_LSB];
  end

  assign unused_insn_bits = ^{insn[INS_WIDTH-1:X_STRIDE_MSB+1],
                              insn[SRAM_BASE_LSB-1:OPCODE_MSB+1]};
  assign unused_rd_sum    = ^rd_sum[31:ACC_IDX_WIDTH];

  store_skid_buf #(
    .DATA_W (INP_MEM_WIDTH),
    .ADDR_W (DRAM_ADDR_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (infl_q),
    .in_data   (out_mem_rd_data),
    .in_addr   (infl_addr_q),
    .in_last   (infl_last_q),
    .out_valid (st_valid),
    .out_data  (st_data),
    .out_addr  (st_addr),
    .out_last  (st_last),
    .out_ready (st_ready),
    .occupancy (occupancy)
  );

  // Next-state, address generation and read issue for the tile walk
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    x_size_d    = x_size_q;
    y_size_d    = y_size_q;
    x_stride_d  = x_stride_q;
    row_sram_d  = row_sram_q;
    row_dram_d  = row_dram_q;
    done_d      = (state_q == ST_FIN);
    accept      = 1'b0;

    insn_ready     = (state_q == ST_IDLE);
    rd_sum         = row_sram_q + {16'b0, x_q};
    beat_word      = row_dram_q + {16'b0, x_q};
    beat_addr_full = beat_word << BEAT_BYTES_LOG2;
    row_end        = (x_q == x_size_q - 16'd1);
    last_rd        = row_end && (y_q == y_size_q - 16'd1);
    beat_fire      = st_valid && st_ready;
    // Credit counts both parked entries and the read whose data returns next cycle.
    pending        = {1'b0, occupancy} + {2'b0, infl_q};
    credit_ok      = (pending < 3'd2);
    // Nothing left once this cycle's transfer (if any) completes.
    drain_clear    = (pending == 3'd0) || ((pending == 3'd1) && beat_fire);

    out_mem_rd_en   = 1'b0;
    out_mem_rd_addr = rd_sum[ACC_IDX_WIDTH-1:0];

    case (state_q)
      ST_IDLE: begin
        if (insn_valid) begin
          accept     = 1'b1;
          x_d        = '0;
          y_d        = '0;
          x_size_d   = dec.x_size;
          y_size_d   = dec.y_size;
          x_stride_d = dec.x_stride;
          row_sram_d = {16'b0, dec.sram_base};
          row_dram_d = dec.dram_base;
          if ((dec.opcode != OPCODE_STORE) || (dec.y_size == 16'd0) ||
              (dec.x_size == 16'd0)) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (credit_ok) begin
          out_mem_rd_en = 1'b1;
          if (row_end) begin
            x_d        = '0;
            y_d        = y_q + 16'd1;
            row_sram_d = row_sram_q + {16'b0, x_size_q};
            row_dram_d = row_dram_q + {16'b0, x_stride_q};
          end else begin
            x_d = x_q + 16'd1;
          end
          if (last_rd) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_clear) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    infl_d      = out_mem_rd_en;
    infl_addr_d = beat_addr_full[DRAM_ADDR_WIDTH-1:0];
    infl_last_d = out_mem_rd_en && last_rd;
  end

  assign done = done_q;

  // FSM, counters, row bases and read-pipeline registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      x_size_q    <= '0;
      y_size_q    <= '0;
      x_stride_q  <= '0;
      row_sram_q  <= '0;
      row_dram_q  <= '0;
      infl_q      <= 1'b0;
      infl_addr_q <= '0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      x_size_q    <= x_size_d;
      y_size_q    <= y_size_d;
      x_stride_q  <= x_stride_d;
      row_sram_q  <= row_sram_d;
      row_dram_q  <= row_dram_d;
      infl_q      <= infl_d;
      infl_addr_q <= infl_addr_d;
      infl_last_q <= infl_last_d;
      done_q      <= done_d;
    end
  end

`ifdef STORE_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating back-pressure counter, restarted by each accepted instruction
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (accept) begin
      stall_cnt_d = '0;
    end else if (st_valid && !st_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule
